// File: rtl/param_readout_sequencer.sv
// Timing generator for a linear photodiode array: sensor pins plus round-robin ADC triggers.
// Latency: STI/IRST rise the cycle after start is sampled; every output is registered.
// Backpressure: none; start is ignored while busy, stop ends the run after the current frame.
module param_readout_sequencer #(
  parameter int NUM_PIXELS   = 128,
  parameter int EXTRA_CLKS   = 5,
  parameter int NUM_ADCS     = 4,
  parameter int CLK_HALF     = 15,
  parameter int T_PULSE      = 5,
  parameter int T_HOLD       = 2,
  parameter int T_SETUP      = 5,
  parameter int T_SHR_DELAY  = 60,
  parameter int T_INTG_DELAY = 5,
  parameter int T_SHS_DELAY  = 675,
  parameter int T_END        = 5,
  parameter int MIN_INTG     = 2100,
  localparam int PIX_W       = $clog2(NUM_PIXELS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                continuous,
  input  logic                stop,
  input  logic [31:0]         intg_cycles,
  output logic                busy,
  output logic                frame_done,
  output logic [15:0]         frame_count,
  output logic                intg_clamped,
  output logic [NUM_ADCS-1:0] start_adc,
  output logic [PIX_W-1:0]    pixel_index,
  output logic                STI,
  output logic                IRST,
  output logic                CLK,
  output logic                SHR,
  output logic                INTG,
  output logic                SHS
);

  localparam int ADC_W = (NUM_ADCS > 1) ? $clog2(NUM_ADCS) : 1;
  localparam logic [NUM_ADCS-1:0] ADC_ONE = NUM_ADCS'(1);

  // Compare values are "last cycle of the condition" so the registered output lands on the
  // exact cycle. SHR_WAIT starts at the fall of the last CLK pulse (CL + CLK_HALF), so the
  // SHR delays are rebased by CLK_HALF; this assumes T_SHR_DELAY > CLK_HALF and
  // T_INTG_DELAY >= T_PULSE (SHR has fallen by the time INTG rises).
  localparam logic [31:0] STI_END    = 32'(T_PULSE - 1);
  localparam logic [31:0] IRST_END   = 32'(T_PULSE + T_HOLD - 1);
  localparam logic [31:0] RST_END    = 32'(T_PULSE + T_HOLD + T_SETUP - 1);
  localparam logic [31:0] HALF_END   = 32'(CLK_HALF - 1);
  localparam logic [31:0] PERIOD_END = 32'(2 * CLK_HALF - 1);
  localparam logic [31:0] LAST_PULSE = 32'(NUM_PIXELS + EXTRA_CLKS - 1);
  localparam logic [31:0] NPIX       = 32'(NUM_PIXELS);
  localparam logic [31:0] SHR_ON     = 32'(T_SHR_DELAY - CLK_HALF - 1);
  localparam logic [31:0] SHR_OFF    = 32'(T_SHR_DELAY - CLK_HALF + T_PULSE - 1);
  localparam logic [31:0] INTG_ON    = 32'(T_SHR_DELAY - CLK_HALF + T_INTG_DELAY - 1);
  localparam logic [31:0] SHS_ON     = 32'(T_SHS_DELAY - 1);
  localparam logic [31:0] SHS_OFF    = 32'(T_SHS_DELAY + T_PULSE - 1);
  localparam logic [31:0] DONE_ON    = 32'(T_END - 1);
  localparam logic [31:0] DONE_CYC   = 32'(T_END);
  localparam logic [31:0] MIN_L      = 32'(MIN_INTG);

  typedef enum logic [2:0] {
    S_IDLE, S_RST, S_READ, S_SHR_WAIT, S_INTEG, S_SHS_WAIT, S_TAIL
  } state_t;

  state_t             state;
  logic [31:0]        cnt;
  logic [31:0]        phase;
  logic [31:0]        pulse;
  logic [ADC_W-1:0]   adc_sel;
  logic [31:0]        intg_len;
  logic               stop_latch;
  logic               launch;

  // A frame begins from idle on start, or back-to-back from the frame_done cycle when running continuously
  always_comb begin
    launch = 1'b0;
    if (state == S_IDLE && start)
      launch = 1'b1;
    else if (state == S_TAIL && cnt == DONE_CYC && continuous && !stop_latch && !stop)
      launch = 1'b1;
  end

  // Frame sequencer: each branch decides what the pins look like on the following cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      phase        <= '0;
      pulse        <= '0;
      adc_sel      <= '0;
      intg_len     <= '0;
      stop_latch   <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      frame_count  <= '0;
      intg_clamped <= 1'b0;
      start_adc    <= '0;
      pixel_index  <= '0;
      STI          <= 1'b0;
      IRST         <= 1'b0;
      CLK          <= 1'b0;
      SHR          <= 1'b0;
      INTG         <= 1'b0;
      SHS          <= 1'b0;
    end else begin
      start_adc  <= '0;
      frame_done <= 1'b0;
      cnt        <= cnt + 32'd1;
      if (busy && stop) stop_latch <= 1'b1;

      case (state)
        S_IDLE: cnt <= '0;

        S_RST: begin
          if (cnt == STI_END)  STI  <= 1'b0;
          if (cnt == IRST_END) IRST <= 1'b0;
          if (cnt == RST_END) begin
            state <= S_READ;
            cnt   <= '0;
            phase <= '0;
            pulse <= '0;
            CLK   <= 1'b1;
          end
        end

        S_READ: begin
          if (phase == HALF_END) begin
            CLK <= 1'b0;
            // Only real pixels convert; the trailing EXTRA_CLKS pulses just flush the shift register
            if (pulse < NPIX) begin
              start_adc   <= ADC_ONE << adc_sel;
              pixel_index <= pulse[PIX_W-1:0];
              adc_sel     <= (adc_sel == ADC_W'(NUM_ADCS - 1)) ? '0 : adc_sel + 1'b1;
            end
            if (pulse == LAST_PULSE) begin
              state <= S_SHR_WAIT;
              cnt   <= '0;
            end
          end
          if (phase == PERIOD_END) begin
            phase <= '0;
            pulse <= pulse + 32'd1;
            CLK   <= 1'b1;
          end else begin
            phase <= phase + 32'd1;
          end
        end

        S_SHR_WAIT: begin
          if (cnt == SHR_ON)  SHR <= 1'b1;
          if (cnt == SHR_OFF) SHR <= 1'b0;
          if (cnt == INTG_ON) begin
            INTG  <= 1'b1;
            state <= S_INTEG;
            cnt   <= '0;
          end
        end

        S_INTEG: begin
          if (cnt == intg_len - 32'd1) begin
            INTG  <= 1'b0;
            state <= S_SHS_WAIT;
            cnt   <= '0;
          end
        end

        S_SHS_WAIT: begin
          if (cnt == SHS_ON) SHS <= 1'b1;
          if (cnt == SHS_OFF) begin
            SHS   <= 1'b0;
            state <= S_TAIL;
            cnt   <= '0;
          end
        end

        S_TAIL: begin
          if (cnt == DONE_ON) begin
            frame_done  <= 1'b1;
            frame_count <= frame_count + 16'd1;
          end
          if (cnt == DONE_CYC && !launch) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            stop_latch <= 1'b0;
          end
        end

        default: state <= S_IDLE;
      endcase

      // Integration length is captured once per frame so host writes never disturb a frame in flight
      if (launch) begin
        state        <= S_RST;
        cnt          <= '0;
        adc_sel      <= '0;
        busy         <= 1'b1;
        stop_latch   <= 1'b0;
        STI          <= 1'b1;
        IRST         <= 1'b1;
        intg_len     <= (intg_cycles < MIN_L) ? MIN_L : intg_cycles;
        intg_clamped <= (intg_cycles < MIN_L);
      end
    end
  end

endmodule

// File: tb/tb_param_readout_sequencer.sv
// Bench for param_readout_sequencer: default geometry plus a 256-pixel / 2-ADC instance.
// Every frame is compared cycle by cycle with a waveform computed from the timing equations.
// Directed sequences cover clamping, continuous runs with stop, and reset mid-frame.
module tb_param_readout_sequencer;

  localparam int TP = 5, THOLD = 2, TSET = 5, TSHR = 60, TID = 5, TSHS = 675, TEND = 5;
  localparam int EXTRA = 5, MINI = 2100;
  localparam int C0 = TP + THOLD + TSET;

  typedef struct packed {
    logic        busy, sti, irst, clk, shr, intg, shs, fdone, clamp;
    logic [7:0]  adc;
    logic [15:0] pix;
    logic [15:0] fc;
  } obs_t;

  typedef struct {
    logic [31:0] intg;
    int          exp_l;
    logic        exp_clamp;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, start, start_b, continuous, stop;
  logic [31:0] intg_cycles;

  logic        busy_a, fd_a, cl_a, sti_a, irst_a, clk_a, shr_a, intg_a, shs_a;
  logic [15:0] fc_a;
  logic [3:0]  adc_a;
  logic [6:0]  pix_a;
  logic        busy_b, fd_b, cl_b, sti_b, irst_b, clk_b, shr_b, intg_b, shs_b;
  logic [15:0] fc_b;
  logic [1:0]  adc_b;
  logic [7:0]  pix_b;

  int n_assert = 0;
  int n_fail   = 0;
  int fc_exp   = 0;

  int ev_sti_fall[2], ev_irst_fall[2], ev_clk_first[2], ev_clk_last[2], ev_shr[2];
  int ev_intg_first[2], ev_intg_last[2], ev_shs[2], ev_fd[2];
  int adc_n[2], adc_last_pix[2], adc_last_cyc[2];

  obs_t obs[2];

  always #5 clk = ~clk;

  param_readout_sequencer dut_a (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous), .stop(stop),
    .intg_cycles(intg_cycles), .busy(busy_a), .frame_done(fd_a), .frame_count(fc_a),
    .intg_clamped(cl_a), .start_adc(adc_a), .pixel_index(pix_a),
    .STI(sti_a), .IRST(irst_a), .CLK(clk_a), .SHR(shr_a), .INTG(intg_a), .SHS(shs_a)
  );

  param_readout_sequencer #(.NUM_PIXELS(256), .NUM_ADCS(2), .CLK_HALF(8)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .continuous(continuous), .stop(stop),
    .intg_cycles(intg_cycles), .busy(busy_b), .frame_done(fd_b), .frame_count(fc_b),
    .intg_clamped(cl_b), .start_adc(adc_b), .pixel_index(pix_b),
    .STI(sti_b), .IRST(irst_b), .CLK(clk_b), .SHR(shr_b), .INTG(intg_b), .SHS(shs_b)
  );

  always_comb begin
    obs[0] = '0;
    obs[0].busy = busy_a; obs[0].sti = sti_a; obs[0].irst = irst_a; obs[0].clk = clk_a;
    obs[0].shr = shr_a; obs[0].intg = intg_a; obs[0].shs = shs_a; obs[0].fdone = fd_a;
    obs[0].clamp = cl_a; obs[0].adc = 8'(adc_a); obs[0].pix = 16'(pix_a); obs[0].fc = fc_a;
    obs[1] = '0;
    obs[1].busy = busy_b; obs[1].sti = sti_b; obs[1].irst = irst_b; obs[1].clk = clk_b;
    obs[1].shr = shr_b; obs[1].intg = intg_b; obs[1].shs = shs_b; obs[1].fdone = fd_b;
    obs[1].clamp = cl_b; obs[1].adc = 8'(adc_b); obs[1].pix = 16'(pix_b); obs[1].fc = fc_b;
  end

  task automatic chk(input string name, input int act, input int req);
    n_assert++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  // Frame-relative cycle of frame_done, straight from the timing equations
  function automatic int frame_end(input int l, input int np, input int h);
    int cl;
    cl = C0 + 2 * (np + EXTRA - 1) * h;
    return cl + TSHR + TID + l + TSHS + TP + TEND;
  endfunction

  // Expected pin/trigger values on frame cycle c
  function automatic obs_t model(input int c, input int l, input logic clamp,
                                 input int np, input int nadc, input int h);
    obs_t m;
    int cl, k, p, ie, fd;
    cl = C0 + 2 * (np + EXTRA - 1) * h;
    ie = cl + TSHR + TID + l;
    fd = frame_end(l, np, h);
    m = '0;
    m.busy  = (c <= fd);
    m.sti   = (c < TP);
    m.irst  = (c < TP + THOLD);
    k = c - C0;
    if (k >= 0 && k < 2 * (np + EXTRA) * h) begin
      m.clk = ((k % (2 * h)) < h);
      p = k / (2 * h);
      if ((k % (2 * h)) == h && p < np) begin
        m.adc = 8'(1 << (p % nadc));
        m.pix = 16'(p);
      end
    end
    m.shr   = (c >= cl + TSHR) && (c < cl + TSHR + TP);
    m.intg  = (c >= cl + TSHR + TID) && (c < ie);
    m.shs   = (c >= ie + TSHS) && (c < ie + TSHS + TP);
    m.fdone = (c == fd);
    m.clamp = clamp;
    return m;
  endfunction

  // Entered at the negedge inside frame cycle 0; returns at the negedge after frame_done
  task automatic check_frame(input int inst, input int l, input logic clamp,
                             input int exp_count, input logic expect_idle);
    int np, nadc, h, fd, bad, first_bad;
    obs_t o, m, prev, bad_o, bad_m;
    np   = (inst == 0) ? 128 : 256;
    nadc = (inst == 0) ? 4 : 2;
    h    = (inst == 0) ? 15 : 8;
    fd   = frame_end(l, np, h);
    bad = 0; first_bad = -1; prev = '0; bad_o = '0; bad_m = '0;
    ev_sti_fall[inst] = -1; ev_irst_fall[inst] = -1; ev_clk_first[inst] = -1;
    ev_clk_last[inst] = -1; ev_shr[inst] = -1; ev_intg_first[inst] = -1;
    ev_intg_last[inst] = -1; ev_shs[inst] = -1; ev_fd[inst] = -1;
    adc_n[inst] = 0; adc_last_pix[inst] = -1; adc_last_cyc[inst] = -1;
    for (int c = 0; c <= fd; c++) begin
      o = obs[inst];
      m = model(c, l, clamp, np, nadc, h);
      if (prev.sti && !o.sti && ev_sti_fall[inst] < 0) ev_sti_fall[inst] = c;
      if (prev.irst && !o.irst && ev_irst_fall[inst] < 0) ev_irst_fall[inst] = c;
      if (o.clk && !prev.clk) begin
        if (ev_clk_first[inst] < 0) ev_clk_first[inst] = c;
        ev_clk_last[inst] = c;
      end
      if (o.shr && !prev.shr && ev_shr[inst] < 0) ev_shr[inst] = c;
      if (o.intg) begin
        if (ev_intg_first[inst] < 0) ev_intg_first[inst] = c;
        ev_intg_last[inst] = c;
      end
      if (o.shs && !prev.shs && ev_shs[inst] < 0) ev_shs[inst] = c;
      if (o.fdone) ev_fd[inst] = c;
      if (o.adc != 0) begin
        adc_n[inst]++;
        adc_last_pix[inst] = int'(o.pix);
        adc_last_cyc[inst] = c;
      end
      prev = o;
      o.fc = '0;
      if (m.adc == 0) o.pix = '0;
      if (o != m) begin
        if (first_bad < 0) begin
          first_bad = c; bad_o = o; bad_m = m;
        end
        bad++;
      end
      @(negedge clk);
    end
    n_assert++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL wave[%0d]: %0d cycles differ, required 0 (first at cycle %0d: got %h, required %h)",
               inst, bad, first_bad, bad_o, bad_m);
    end
    o = obs[inst];
    chk($sformatf("frame_count[%0d]", inst), int'(o.fc), exp_count);
    if (expect_idle) chk($sformatf("idle_after_done[%0d]", inst), int'(o.busy), 0);
    else             chk($sformatf("restart_sti[%0d]", inst), int'(o.sti), 1);
  endtask

  task automatic start_frame(input logic [31:0] ic, input logic with_stop, input logic scramble);
    @(negedge clk);
    intg_cycles = ic;
    start = 1'b1;
    stop  = with_stop;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    if (scramble) intg_cycles = $urandom;
  endtask

  vec_t tbl[4];

  initial begin
    int ic, l, seen;
    tbl[0] = '{intg: 32'd3000, exp_l: 3000, exp_clamp: 1'b0};
    tbl[1] = '{intg: 32'd100,  exp_l: 2100, exp_clamp: 1'b1};
    tbl[2] = '{intg: 32'd5000, exp_l: 5000, exp_clamp: 1'b0};
    tbl[3] = '{intg: 32'd2100, exp_l: 2100, exp_clamp: 1'b0};

    reset = 1'b1; start = 1'b0; start_b = 1'b0; continuous = 1'b0; stop = 1'b0;
    intg_cycles = 32'd3000;
    repeat (3) @(negedge clk);
    chk("reset_busy", int'(busy_a), 0);
    chk("reset_pins", int'({sti_a, irst_a, clk_a, shr_a, intg_a, shs_a}), 0);
    chk("reset_adc", int'(adc_a), 0);
    chk("reset_frame_count", int'(fc_a), 0);
    chk("reset_done_clamp", int'({fd_a, cl_a}), 0);
    reset = 1'b0;
    // stop while idle must not leak into the next frame
    @(negedge clk); stop = 1'b1; @(negedge clk); stop = 1'b0;

    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      intg_cycles = tbl[i].intg;
      start   = 1'b1;
      start_b = (i == 0);
      @(negedge clk);
      start = 1'b0; start_b = 1'b0;
      intg_cycles = $urandom;
      fc_exp++;
      if (i == 0) begin
        fork
          check_frame(0, tbl[0].exp_l, tbl[0].exp_clamp, fc_exp, 1'b1);
          check_frame(1, tbl[0].exp_l, tbl[0].exp_clamp, 1, 1'b1);
        join
        chk("sti_fall", ev_sti_fall[0], 5);
        chk("irst_fall", ev_irst_fall[0], 7);
        chk("clk_first_rise", ev_clk_first[0], 12);
        chk("clk_last_rise", ev_clk_last[0], 3972);
        chk("shr_rise", ev_shr[0], 4032);
        chk("intg_first", ev_intg_first[0], 4037);
        chk("intg_last", ev_intg_last[0], 7036);
        chk("shs_rise", ev_shs[0], 7712);
        chk("frame_done_cycle", ev_fd[0], 7722);
        chk("adc_pulses", adc_n[0], 128);
        chk("adc_last_pixel", adc_last_pix[0], 127);
        chk("adc_last_cycle", adc_last_cyc[0], 3837);
        chk("b_adc_pulses", adc_n[1], 256);
        chk("b_adc_last_pixel", adc_last_pix[1], 255);
        chk("b_clk_last_rise", ev_clk_last[1], 4172);
      end else begin
        check_frame(0, tbl[i].exp_l, tbl[i].exp_clamp, fc_exp, 1'b1);
      end
      chk($sformatf("intg_width[%0d]", i), ev_intg_last[0] - ev_intg_first[0] + 1, tbl[i].exp_l);
      chk($sformatf("clamped_after[%0d]", i), int'(cl_a), int'(tbl[i].exp_clamp));
    end

    // Random integration request against the max(request, minimum) rule
    ic = int'($urandom_range(0, 2600));
    l  = (ic < MINI) ? MINI : ic;
    start_frame(32'(ic), 1'b0, 1'b1);
    fc_exp++;
    check_frame(0, l, (ic < MINI), fc_exp, 1'b1);

    // Continuous run: start+stop together (start wins), stop and a busy start in frame 3
    continuous = 1'b1;
    start_frame(32'd100, 1'b1, 1'b0);
    check_frame(0, MINI, 1'b1, fc_exp + 1, 1'b0);
    check_frame(0, MINI, 1'b1, fc_exp + 2, 1'b0);
    fork
      check_frame(0, MINI, 1'b1, fc_exp + 3, 1'b1);
      begin
        repeat (1500) @(negedge clk);
        stop = 1'b1; start = 1'b1;
        @(negedge clk);
        stop = 1'b0; start = 1'b0;
      end
    join
    fc_exp += 3;
    repeat (5) @(negedge clk);
    chk("idle_after_stop", int'(busy_a), 0);
    continuous = 1'b0;

    // Reset during READ aborts the frame without frame_done
    start_frame(32'd100, 1'b0, 1'b1);
    repeat (2000) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_pins", int'({sti_a, irst_a, clk_a, shr_a, intg_a, shs_a}), 0);
    chk("midreset_busy_adc", int'({busy_a, adc_a}), 0);
    chk("midreset_frame_count", int'(fc_a), 0);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(negedge clk);
      if (fd_a || busy_a) seen++;
    end
    chk("no_done_after_reset", seen, 0);
    start_frame(32'd100, 1'b0, 1'b1);
    check_frame(0, MINI, 1'b1, 1, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
